// File: rtl/conv_sched_if.sv
// Handshake/result bundle between conv_sched and its neighbours.
// master: the scheduler side; slave: layer control + convolve engine side.
interface conv_sched_if #(
  parameter int KERNEL_SIZE = 3,
  parameter int IMGROW      = 32,
  parameter int IMGCOL      = 32
);
  localparam int PAD   = (KERNEL_SIZE - 1) / 2;
  localparam int OUT_N = (IMGROW - 2 * PAD) * (IMGCOL - 2 * PAD);
  localparam int RW    = (IMGROW > 1) ? $clog2(IMGROW) : 1;
  localparam int CW    = (IMGCOL > 1) ? $clog2(IMGCOL) : 1;
  localparam int AW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          win_valid;
  logic          win_ready;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          en_convolve;
  logic          out_valid;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic [AW-1:0] out_addr;
  logic          out_last;

  modport master (
    input  start, abort, win_ready,
    output busy, done, win_valid, win_row, win_col, en_convolve,
           out_valid, out_row, out_col, out_addr, out_last
  );

  modport slave (
    output start, abort, win_ready,
    input  busy, done, win_valid, win_row, win_col, en_convolve,
           out_valid, out_row, out_col, out_addr, out_last
  );
endinterface

// File: rtl/conv_sched.sv
// Convolution sequencing controller: walks every unpadded output position
// in row-major order, issues window requests under valid/ready, and carries
// each request's tags through a fixed-latency shadow pipe so results leave
// tagged with their coordinates and linear feature-map address.
module conv_sched #(
  parameter int KERNEL_SIZE = 3,
  parameter int IMGROW      = 32,
  parameter int IMGCOL      = 32,
  parameter int PIPE_LAT    = 3
) (
  input  logic         clk,
  input  logic         rst,
  conv_sched_if.master bus
);
  localparam int PAD    = (KERNEL_SIZE - 1) / 2;
  localparam int OUT_N  = (IMGROW - 2 * PAD) * (IMGCOL - 2 * PAD);
  localparam int RW     = (IMGROW > 1) ? $clog2(IMGROW) : 1;
  localparam int CW     = (IMGCOL > 1) ? $clog2(IMGCOL) : 1;
  localparam int AW     = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int STAGES = PIPE_LAT - 1;

  localparam logic [RW-1:0] ROW_FIRST = RW'(PAD);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMGROW - 1 - PAD);
  localparam logic [CW-1:0] COL_FIRST = CW'(PAD);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMGCOL - 1 - PAD);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [AW-1:0] addr;
    logic          last;
  } tag_t;

  state_t        state;
  logic          busy_q;
  logic          done_q;
  logic          win_valid_q;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [AW-1:0] addr;

  logic              hs;
  logic              at_last;
  tag_t              cur_tag;
  logic [STAGES:0]   vld_pipe;
  tag_t [STAGES:0]   tag_pipe;
  logic              tail_last;

  assign hs        = win_valid_q && bus.win_ready;
  assign at_last   = (row == ROW_LAST) && (col == COL_LAST);
  assign cur_tag   = '{row: row, col: col, addr: addr, last: at_last};
  assign tail_last = vld_pipe[STAGES] && tag_pipe[STAGES].last;

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.win_valid   = win_valid_q;
  assign bus.win_row     = row;
  assign bus.win_col     = col;
  assign bus.en_convolve = hs;
  assign bus.out_valid   = vld_pipe[STAGES];
  assign bus.out_row     = tag_pipe[STAGES].row;
  assign bus.out_col     = tag_pipe[STAGES].col;
  assign bus.out_addr    = tag_pipe[STAGES].addr;
  assign bus.out_last    = tail_last;

  // Pass sequencer: state, position counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
      row         <= '0;
      col         <= '0;
      addr        <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        // cancel wins over everything, including a same-cycle start
        state       <= IDLE;
        busy_q      <= 1'b0;
        win_valid_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state       <= RUN;
              busy_q      <= 1'b1;
              win_valid_q <= 1'b1;
              row         <= ROW_FIRST;
              col         <= COL_FIRST;
              addr        <= '0;
            end
          end
          RUN: begin
            // counters only move on an accepted request; a stall holds them
            if (hs) begin
              addr <= addr + AW'(1);
              if (col == COL_LAST) begin
                col <= COL_FIRST;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
              if (at_last) begin
                state       <= DRAIN;
                win_valid_q <= 1'b0;
              end
            end
          end
          DRAIN: begin
            if (tail_last) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Latency-matching shadow pipe; shifts every cycle, abort kills in-flight valids.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      if (bus.abort) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[0] <= hs;
        for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
      tag_pipe[0] <= cur_tag;
      for (int i = 1; i <= STAGES; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end
endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: a 5x5 instance and a default 32x32 instance, both
// checked every cycle against a timeline model built from position index
// arithmetic and a queue of (due cycle, index) entries.
module tb_conv_sched;
  localparam int LAT = 3;
  localparam int PAD = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_sched_if #(.KERNEL_SIZE(3), .IMGROW(5), .IMGCOL(5)) sif();
  conv_sched_if bif();

  conv_sched #(.KERNEL_SIZE(3), .IMGROW(5), .IMGCOL(5), .PIPE_LAT(LAT)) dut_s (
    .clk(clk), .rst(rst), .bus(sif.master));
  conv_sched dut_b (.clk(clk), .rst(rst), .bus(bif.master));

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // model state per instance (0: 5x5, 1: 32x32)
  int MW[2] = '{3, 30};
  int MN[2] = '{9, 900};
  bit act[2];
  int k[2];
  int lcyc[2];
  int qdue[2][$];
  int qidx[2][$];
  int dres[2];
  int dlast[2];
  int la_addr, la_row, la_col;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int i, input logic st, input logic ab, input logic rdy,
                       input logic bsy, input logic dn, input logic wv,
                       input int wr, input int wc, input logic en, input logic ov,
                       input int orow, input int ocol, input int oaddr, input logic olast);
    string p;
    bit e_wv, e_ov, e_dn;
    int idx;
    p = (i == 0) ? "s" : "b";
    if (!rst) begin
      act[i] = 0; lcyc[i] = -10;
      qdue[i].delete(); qidx[i].delete();
      chk({p, "_rst_busy"}, bsy, 0);
      chk({p, "_rst_done"}, dn, 0);
      chk({p, "_rst_win_valid"}, wv, 0);
      chk({p, "_rst_en"}, en, 0);
      chk({p, "_rst_out_valid"}, ov, 0);
      chk({p, "_rst_out_last"}, olast, 0);
      chk({p, "_rst_win_row"}, wr, 0);
      chk({p, "_rst_win_col"}, wc, 0);
      chk({p, "_rst_out_row"}, orow, 0);
      chk({p, "_rst_out_col"}, ocol, 0);
      chk({p, "_rst_out_addr"}, oaddr, 0);
      return;
    end
    e_wv = act[i] && (k[i] < MN[i]);
    e_ov = (qdue[i].size() > 0) && (qdue[i][0] == cyc);
    idx  = e_ov ? qidx[i][0] : -1;
    e_dn = act[i] && (lcyc[i] >= 0) && (cyc == lcyc[i] + 1);

    chk({p, "_busy"}, bsy, int'(act[i]));
    chk({p, "_done"}, dn, int'(e_dn));
    chk({p, "_win_valid"}, wv, int'(e_wv));
    chk({p, "_en_convolve"}, en, int'(e_wv && rdy));
    if (e_wv) begin
      chk({p, "_win_row"}, wr, PAD + k[i] / MW[i]);
      chk({p, "_win_col"}, wc, PAD + k[i] % MW[i]);
    end
    chk({p, "_out_valid"}, ov, int'(e_ov));
    chk({p, "_out_last"}, olast, int'(e_ov && idx == MN[i] - 1));
    if (e_ov) begin
      chk({p, "_out_addr"}, oaddr, idx);
      chk({p, "_out_row"}, orow, PAD + idx / MW[i]);
      chk({p, "_out_col"}, ocol, PAD + idx % MW[i]);
    end
    if (ov) dres[i]++;
    if (olast) begin
      dlast[i]++;
      la_addr = oaddr; la_row = orow; la_col = ocol;
    end

    // advance the timeline to the end of this cycle
    if (e_ov) begin
      void'(qdue[i].pop_front());
      void'(qidx[i].pop_front());
      if (idx == MN[i] - 1) lcyc[i] = cyc;
    end
    if (e_wv && rdy) begin
      qdue[i].push_back(cyc + LAT);
      qidx[i].push_back(k[i]);
      k[i]++;
    end
    if (ab) begin
      act[i] = 0; lcyc[i] = -10;
      qdue[i].delete(); qidx[i].delete();
    end else if (e_dn) begin
      act[i] = 0; lcyc[i] = -10;
    end else if (!act[i] && st) begin
      act[i] = 1; k[i] = 0; lcyc[i] = -10;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model(0, sif.start, sif.abort, sif.win_ready, sif.busy, sif.done, sif.win_valid,
          int'(sif.win_row), int'(sif.win_col), sif.en_convolve, sif.out_valid,
          int'(sif.out_row), int'(sif.out_col), int'(sif.out_addr), sif.out_last);
    model(1, bif.start, bif.abort, bif.win_ready, bif.busy, bif.done, bif.win_valid,
          int'(bif.win_row), int'(bif.win_col), bif.en_convolve, bif.out_valid,
          int'(bif.out_row), int'(bif.out_col), int'(bif.out_addr), bif.out_last);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int i, input logic st, input logic ab, input logic rdy);
    if (i == 0) begin
      sif.start = st; sif.abort = ab; sif.win_ready = rdy;
    end else begin
      bif.start = st; bif.abort = ab; bif.win_ready = rdy;
    end
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1; 2: random ready (and random start on the 5x5)
  task automatic run(input int i, input int mode, input int bound);
    int n;
    logic r;
    n = 0;
    while (act[i] && n < bound) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (n % 4 == 0) || (n % 4 == 3);
        default: r = ($urandom % 4) != 0;
      endcase
      drive(i, (mode == 2 && i == 0) ? logic'($urandom % 5 == 0) : 1'b0, 1'b0, r);
      cycle();
      n++;
    end
    drive(i, 1'b0, 1'b0, 1'b0);
    chk((i == 0) ? "s_pass_timeout" : "b_pass_timeout", act[i], 0);
  endtask

  task automatic start_pass(input int i, input logic rdy);
    drive(i, 1'b1, 1'b0, rdy);
    cycle();
    drive(i, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    int n;
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; k[i] = 0; lcyc[i] = -10; dres[i] = 0; dlast[i] = 0;
    end
    #1;
    repeat (3) cycle();
    rst = 1'b1;
    repeat (5) cycle();

    // full pass, ready held high
    start_pass(0, 1'b1);
    run(0, 0, 40);
    repeat (2) cycle();

    // stalls: ready toggles 1,0,0,1
    dres[0] = 0;
    start_pass(0, 1'b1);
    run(0, 1, 100);
    chk("s_stall_results", dres[0], 9);
    repeat (2) cycle();

    // random ready with spurious start pulses during RUN/DRAIN
    dres[0] = 0; dlast[0] = 0;
    start_pass(0, 1'b1);
    run(0, 2, 200);
    chk("s_spurious_start_results", dres[0], 9);
    chk("s_spurious_start_last", dlast[0], 1);
    repeat (2) cycle();

    // abort on the 5th handshake, then a clean pass
    start_pass(0, 1'b1);
    repeat (4) cycle();
    drive(0, 1'b0, 1'b1, 1'b1);
    cycle();
    drive(0, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle();
    dres[0] = 0;
    start_pass(0, 1'b1);
    run(0, 0, 40);
    chk("s_post_abort_results", dres[0], 9);

    // random start/abort/ready soup
    repeat (400) begin
      drive(0, logic'($urandom % 8 == 0), logic'($urandom % 30 == 0), logic'($urandom % 4 != 0));
      cycle();
    end
    drive(0, 0, 0, 0);
    repeat (8) cycle();

    // asynchronous reset while draining
    start_pass(0, 1'b1);
    n = 0;
    while (k[0] < MN[0] && n < 40) begin
      cycle();
      n++;
    end
    drive(0, 0, 0, 0);
    cycle();
    #1;
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    repeat (6) cycle();

    // default-size instance
    dres[1] = 0; dlast[1] = 0;
    la_addr = -1; la_row = -1; la_col = -1;
    start_pass(1, 1'b1);
    run(1, 2, 5000);
    chk("b_results", dres[1], 900);
    chk("b_last_count", dlast[1], 1);
    chk("b_last_addr", la_addr, 899);
    chk("b_last_row", la_row, 30);
    chk("b_last_col", la_col, 30);
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
